// File: rtl/proab_rd_stream_pkg.sv
// Shared definitions for the probability read-stream stage: FSM state
// encodings, single-precision constants used across the softmax stages and a
// small helper for sizing occupancy counters.
package proab_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_HALF = 32'h3F00_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  // Bits needed to hold an occupancy value from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/proab_stream_fifo.sv
// Synchronous show-ahead FIFO: head_data always presents the oldest entry,
// pop consumes it. DEPTH must be a power of two so pointers wrap naturally.
module proab_stream_fifo
  import proab_rd_stream_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DW-1:0]                 push_data,
  input  logic                          pop,
  output logic [DW-1:0]                 head_data,
  output logic                          empty,
  output logic                          full,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PINC_C  = PW'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          pop_s;
  logic          push_s;

  assign empty     = (cnt_q == ZERO_C);
  assign full      = (cnt_q == DEPTH_C);
  assign count     = cnt_q;
  assign head_data = mem_q[rd_ptr_q];
  assign pop_s     = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle pops.
  assign push_s    = push & (~full | pop_s);

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= ZERO_C;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PINC_C;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PINC_C;
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + ONE_C;
        2'b01:   cnt_q <= cnt_q - ONE_C;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= push_data;
  end

  proab_stream_fifo_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop_s),
    .full (full)
  );

endmodule

// File: rtl/proab_stream_fifo_chk.sv
// Simulation checker for the prefetch FIFO: a push into a full FIFO is only
// legal when the same cycle also pops.
module proab_stream_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/proab_rd_stream.sv
// Final softmax stage: drains DATA_SIZE words of the probability memory and
// streams them over valid/ready. Reads are prefetched under a credit limit
// (in-flight + buffered <= FIFO_DEPTH) so the FIFO can never overflow and the
// stream sustains one word per cycle without backpressure.
// Optional: define PROAB_ARGMAX_EN to add argmax_idx/argmax_valid, tracking
// the index of the largest word (lowest index wins ties).
module proab_rd_stream
  import proab_rd_stream_pkg::*;
#(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int DATA_SIZE  = 128,
  parameter int RD_DELAY   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_start,
  output logic          rd_ready,
  output logic          rd_done,
  output logic [AW-1:0] rd_addr,
  output logic          rd_ena,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
`ifdef PROAB_ARGMAX_EN
  ,
  output logic [AW-1:0] argmax_idx,
  output logic          argmax_valid
`endif
);

  // Word counters carry one extra bit so DATA_SIZE = 2^AW does not wrap.
  localparam int CW  = AW + 1;
  localparam int FCW = cnt_width(FIFO_DEPTH);
  localparam int SW  = FCW + 1;
  localparam logic [CW-1:0] DS_C    = CW'(DATA_SIZE);
  localparam logic [CW-1:0] LAST_C  = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);

  state_e                state_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         popped_q;
  logic [RD_DELAY-1:0]   vld_sr_q;
  logic [RD_DELAY-1:0]   vld_sr_d;
  logic [FCW-1:0]        fifo_cnt_s;
  logic [SW-1:0]         credit_used_s;
  logic                  issue_s;
  logic                  capture_s;
  logic                  pop_s;
  logic                  last_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [DW-1:0]         head_s;

  // Credits in use are reads still in the memory pipe plus words buffered.
  always_comb begin
    credit_used_s = SW'(fifo_cnt_s);
    for (int i = 0; i < RD_DELAY; i++) begin
      credit_used_s = credit_used_s + SW'(vld_sr_q[i]);
    end
    if ((state_q == ST_RUN) && (issued_q < DS_C) && (credit_used_s < DEPTH_C) && !fifo_full_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Read-valid pipeline mirrors the memory latency; its tail marks returning data.
  always_comb begin
    vld_sr_d    = vld_sr_q;
    vld_sr_d[0] = issue_s;
    for (int i = 1; i < RD_DELAY; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
  end

  assign capture_s = vld_sr_q[RD_DELAY-1];
  assign pop_s     = ~fifo_empty_s & out_ready;
  assign last_s    = (popped_q == LAST_C);

  assign rd_ready  = (state_q == ST_IDLE);
  assign rd_done   = (state_q == ST_DONE);
  assign rd_ena    = issue_s;
  assign rd_addr   = issued_q[AW-1:0];
  assign out_valid = ~fifo_empty_s;
  assign out_data  = fifo_empty_s ? {DW{1'b0}} : head_s;
  assign out_last  = ~fifo_empty_s & last_s;

  // Job FSM with issue/pop counters; reset abandons the job and drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      issued_q <= {CW{1'b0}};
      popped_q <= {CW{1'b0}};
      vld_sr_q <= {RD_DELAY{1'b0}};
    end else begin
      vld_sr_q <= vld_sr_d;
      case (state_q)
        ST_IDLE: begin
          if (rd_start) begin
            state_q  <= ST_RUN;
            issued_q <= {CW{1'b0}};
            popped_q <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          if (issue_s) issued_q <= issued_q + ONE_C;
          if (pop_s)   popped_q <= popped_q + ONE_C;
          if (pop_s && last_s) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  proab_stream_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture_s),
    .push_data (rd_data),
    .pop       (pop_s),
    .head_data (head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .count     (fifo_cnt_s)
  );

`ifdef PROAB_ARGMAX_EN
  logic [DW-1:0] max_val_q;
  logic [AW-1:0] argmax_idx_q;

  // Running maximum as unsigned integers; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val_q    <= {DW{1'b0}};
      argmax_idx_q <= {AW{1'b0}};
    end else if ((state_q == ST_IDLE) && rd_start) begin
      max_val_q    <= {DW{1'b0}};
      argmax_idx_q <= {AW{1'b0}};
    end else if ((state_q == ST_RUN) && pop_s && (head_s > max_val_q)) begin
      max_val_q    <= head_s;
      argmax_idx_q <= popped_q[AW-1:0];
    end
  end

  assign argmax_idx   = argmax_idx_q;
  assign argmax_valid = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_proab_rd_stream.sv
// Directed bench for proab_rd_stream: three instances (RD_DELAY=1, RD_DELAY=3,
// DATA_SIZE=1) each fed by a small behavioural memory with the matching latency.
module tb_proab_rd_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] mem [0:7];
  int checks = 0;
  int errors = 0;

  // instance A: DATA_SIZE=8, RD_DELAY=1
  logic a_rd_start, a_out_ready, a_rd_ready, a_rd_done, a_rd_ena, a_out_valid, a_out_last;
  logic [11:0] a_rd_addr;
  logic [31:0] a_rd_data, a_out_data;
  // instance B: DATA_SIZE=8, RD_DELAY=3
  logic b_rd_start, b_out_ready, b_rd_ready, b_rd_done, b_rd_ena, b_out_valid, b_out_last;
  logic [11:0] b_rd_addr;
  logic [31:0] b_rd_data, b_out_data, b_p1, b_p2;
  // instance C: DATA_SIZE=1, RD_DELAY=1
  logic c_rd_start, c_out_ready, c_rd_ready, c_rd_done, c_rd_ena, c_out_valid, c_out_last;
  logic [11:0] c_rd_addr;
  logic [31:0] c_rd_data, c_out_data;
`ifdef PROAB_ARGMAX_EN
  logic [11:0] a_argmax_idx, b_argmax_idx, c_argmax_idx;
  logic a_argmax_valid, b_argmax_valid, c_argmax_valid;
`endif

  int a_reads = 0;
  int b_reads = 0;
  int c_reads = 0;

  proab_rd_stream #(.AW(12), .DW(32), .DATA_SIZE(8), .RD_DELAY(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rd_start(a_rd_start), .rd_ready(a_rd_ready), .rd_done(a_rd_done),
    .rd_addr(a_rd_addr), .rd_ena(a_rd_ena), .rd_data(a_rd_data), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last)
`ifdef PROAB_ARGMAX_EN
    , .argmax_idx(a_argmax_idx), .argmax_valid(a_argmax_valid)
`endif
  );

  proab_rd_stream #(.AW(12), .DW(32), .DATA_SIZE(8), .RD_DELAY(3), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .rd_start(b_rd_start), .rd_ready(b_rd_ready), .rd_done(b_rd_done),
    .rd_addr(b_rd_addr), .rd_ena(b_rd_ena), .rd_data(b_rd_data), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last)
`ifdef PROAB_ARGMAX_EN
    , .argmax_idx(b_argmax_idx), .argmax_valid(b_argmax_valid)
`endif
  );

  proab_rd_stream #(.AW(12), .DW(32), .DATA_SIZE(1), .RD_DELAY(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .rd_start(c_rd_start), .rd_ready(c_rd_ready), .rd_done(c_rd_done),
    .rd_addr(c_rd_addr), .rd_ena(c_rd_ena), .rd_data(c_rd_data), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_last(c_out_last)
`ifdef PROAB_ARGMAX_EN
    , .argmax_idx(c_argmax_idx), .argmax_valid(c_argmax_valid)
`endif
  );

  // Memory models; junk data when not enabled exposes wrong capture timing.
  always @(posedge clk) begin
    a_rd_data <= a_rd_ena ? mem[a_rd_addr[2:0]] : 32'hDEAD_BEEF;
    c_rd_data <= c_rd_ena ? mem[c_rd_addr[2:0]] : 32'hDEAD_BEEF;
    b_p1      <= b_rd_ena ? mem[b_rd_addr[2:0]] : 32'hDEAD_BEEF;
    b_p2      <= b_p1;
    b_rd_data <= b_p2;
    if (a_rd_ena) a_reads <= a_reads + 1;
    if (b_rd_ena) b_reads <= b_reads + 1;
    if (c_rd_ena) c_reads <= c_reads + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full job on instance A with out_ready following rpat[cycle % 4].
  task automatic stream_a(input logic [3:0] rpat, input string tag);
    int k, c, first_v, done_c, last_c, r0;
    logic stalled;
    logic [31:0] held;
    k = 0; first_v = -1; done_c = -1; last_c = -1; stalled = 1'b0; held = 32'h0;
    @(negedge clk);
    r0 = a_reads;
    a_rd_start = 1'b1;
    a_out_ready = rpat[0];
    for (c = 1; c <= 80 && done_c < 0; c++) begin
      @(negedge clk);
      a_rd_start = 1'b0;
      a_out_ready = rpat[c % 4];
      chk({tag, "_done"}, {31'd0, a_rd_done}, {31'd0, (last_c >= 0) && (c == last_c + 1)});
`ifdef PROAB_ARGMAX_EN
      chk({tag, "_amv"}, {31'd0, a_argmax_valid}, {31'd0, (last_c >= 0) && (c == last_c + 1)});
`endif
      if (a_out_valid && first_v < 0) first_v = c;
      if (stalled) chk({tag, "_hold"}, a_out_data, held);
      if (a_out_valid && a_out_ready) begin
        chk({tag, "_data"}, a_out_data, mem[k]);
        chk({tag, "_last"}, {31'd0, a_out_last}, {31'd0, k == 7});
        if (k == 7) last_c = c;
        k++;
      end
      stalled = a_out_valid && !a_out_ready;
      held = a_out_data;
      if (a_rd_done) done_c = c;
    end
    chk({tag, "_nwords"}, k, 32'd8);
    chk({tag, "_first_valid"}, first_v, 32'd3);
    chk({tag, "_done_at"}, done_c, last_c + 1);
    @(negedge clk);
    chk({tag, "_ready_after"}, {31'd0, a_rd_ready}, 32'd1);
    chk({tag, "_nreads"}, a_reads - r0, 32'd8);
  endtask

  initial begin
    int k, nv, vc, dc, r0;
    logic done;
    rst = 1'b1;
    a_rd_start = 1'b0; a_out_ready = 1'b0;
    b_rd_start = 1'b0; b_out_ready = 1'b0;
    c_rd_start = 1'b0; c_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_ready", {31'd0, a_rd_ready}, 32'd1);
    chk("rst_done", {31'd0, a_rd_done}, 32'd0);
    chk("rst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_last", {31'd0, a_out_last}, 32'd0);
    chk("rst_ena", {31'd0, a_rd_ena}, 32'd0);
    chk("rst_addr", {20'd0, a_rd_addr}, 32'd0);
    chk("rst_data", a_out_data, 32'd0);
`ifdef PROAB_ARGMAX_EN
    chk("rst_amidx", {20'd0, a_argmax_idx}, 32'd0);
    chk("rst_amv", {31'd0, a_argmax_valid}, 32'd0);
`endif

    // full-rate stream, then stalling consumer
    stream_a(4'b1111, "t1");
`ifdef PROAB_ARGMAX_EN
    chk("t1_amidx", {20'd0, a_argmax_idx}, 32'd7);
`endif
    stream_a(4'b1001, "t2");

    // RD_DELAY=3 with consumer stalled: credit limits reads to FIFO_DEPTH
    @(negedge clk);
    r0 = b_reads;
    b_rd_start = 1'b1;
    @(negedge clk);
    b_rd_start = 1'b0;
    repeat (19) @(negedge clk);
    chk("t3_reads_stalled", b_reads - r0, 32'd4);
    chk("t3_valid", {31'd0, b_out_valid}, 32'd1);
    chk("t3_head", b_out_data, mem[0]);
    chk("t3_last_early", {31'd0, b_out_last}, 32'd0);
    b_out_ready = 1'b1;
    k = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (b_out_valid) begin
        chk("t3_data", b_out_data, mem[k]);
        chk("t3_last", {31'd0, b_out_last}, {31'd0, k == 7});
        k++;
      end
      if (b_rd_done) done = 1'b1;
      @(negedge clk);
    end
    chk("t3_nwords", k, 32'd8);
    chk("t3_done_seen", {31'd0, done}, 32'd1);
    chk("t3_ready_after", {31'd0, b_rd_ready}, 32'd1);
    chk("t3_nreads", b_reads - r0, 32'd8);

    // second start mid-job ignored, then reset at word 4
    a_out_ready = 1'b1;
    a_rd_start = 1'b1;
    @(negedge clk);
    chk("t4_busy", {31'd0, a_rd_ready}, 32'd0);
    @(negedge clk);
    a_rd_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_w4_valid", {31'd0, a_out_valid}, 32'd1);
    chk("t4_w4_data", a_out_data, 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_ready", {31'd0, a_rd_ready}, 32'd1);
    chk("t4_valid", {31'd0, a_out_valid}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("t4_quiet_valid", {31'd0, a_out_valid}, 32'd0);
      chk("t4_quiet_done", {31'd0, a_rd_done}, 32'd0);
      chk("t4_quiet_ena", {31'd0, a_rd_ena}, 32'd0);
    end
    stream_a(4'b1111, "t4_fresh");

    // DATA_SIZE=1: single word carries out_last
    c_out_ready = 1'b1;
    r0 = c_reads;
    c_rd_start = 1'b1;
    nv = 0; vc = -1; dc = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      c_rd_start = 1'b0;
      if (c_out_valid) begin
        chk("t5_data", c_out_data, mem[0]);
        chk("t5_last", {31'd0, c_out_last}, 32'd1);
        vc = i;
        nv++;
      end
      if (c_rd_done && dc < 0) dc = i;
    end
    chk("t5_nwords", nv, 32'd1);
    chk("t5_valid_at", vc, 32'd3);
    chk("t5_done_at", dc, 32'd4);
    chk("t5_nreads", c_reads - r0, 32'd1);
    chk("t5_ready_after", {31'd0, c_rd_ready}, 32'd1);

`ifdef PROAB_ARGMAX_EN
    // argmax over {0.1, 0.5, 0.2, 0.5, 0, 0, 0, 0}: tie keeps index 1
    mem[0] = 32'h3DCC_CCCD; mem[1] = 32'h3F00_0000;
    mem[2] = 32'h3E4C_CCCD; mem[3] = 32'h3F00_0000;
    for (int i = 4; i < 8; i++) mem[i] = 32'h0;
    stream_a(4'b1111, "t6");
    chk("t6_amidx", {20'd0, a_argmax_idx}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t6_amidx_hold", {20'd0, a_argmax_idx}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
